// File: rtl/mext_pkg.sv
// RV32M multiply encodings shared by the EX-stage multiply issue logic.
// funct3 / mulsel constants, FSM states, cache tag type, decode helper.
package mext_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [2:0] MS_IDLE   = 3'b000;
  localparam logic [2:0] MS_MUL    = 3'b001;
  localparam logic [2:0] MS_MULH   = 3'b010;
  localparam logic [2:0] MS_MULHSU = 3'b011;
  localparam logic [2:0] MS_MULHU  = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // {funct3, rs1, rs2}
  typedef logic [66:0] mtag_t;

  function automatic logic [2:0] f3_to_mulsel(
    input logic [2:0] f3
  );
    logic [2:0] s;
    s = MS_IDLE;
    unique case (1'b1)
      (f3 == F3_MUL):    s = MS_MUL;
      (f3 == F3_MULH):   s = MS_MULH;
      (f3 == F3_MULHSU): s = MS_MULHSU;
      (f3 == F3_MULHU):  s = MS_MULHU;
      default:           s = MS_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bus between the multiply issue sequencer and the Multiplier.
// master: drives mul_sel/mul_a/mul_b; slave: returns mul_ready/mul_res.
interface mul_issue_ctrl_if;

  logic [2:0]  mul_sel;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ready;
  logic [31:0] mul_res;

  modport master (
    output mul_sel,
    output mul_a,
    output mul_b,
    input  mul_ready,
    input  mul_res
  );

  modport slave (
    input  mul_sel,
    input  mul_a,
    input  mul_b,
    output mul_ready,
    output mul_res
  );

endinterface

// File: rtl/mul_result_cache.sv
// One-entry last-result cache: valid bit, {funct3,rs1,rs2} tag, data.
// Ports: write (wr_*), invalidate (inv), lookup (lk_* -> hit, rd_data).
module mul_result_cache
  import mext_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        inv,
  input  logic [2:0]  wr_f3,
  input  logic [31:0] wr_a,
  input  logic [31:0] wr_b,
  input  logic [31:0] wr_data,
  input  logic [2:0]  lk_f3,
  input  logic [31:0] lk_a,
  input  logic [31:0] lk_b,
  output logic        hit,
  output logic [31:0] rd_data
);

  logic        vld_q;
  mtag_t       tag_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (inv) begin
      vld_q  <= 1'b0;
    end else if (wr_en) begin
      vld_q  <= 1'b1;
      tag_q  <= {wr_f3, wr_a, wr_b};
      data_q <= wr_data;
    end
  end

  assign hit = EN & vld_q &
               (tag_q == {lk_f3, lk_a, lk_b});
  assign rd_data = data_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage multiply sequencer: issue, stall, writeback pulse, timeout.
// Ports: ex_* request, flush, mif (Multiplier bus), stall, wb_*, mul_err.
module mul_issue_ctrl
  import mext_pkg::*;
#(
  parameter bit          CACHE_EN = 1'b1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_mul,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  mul_issue_ctrl_if.master mif,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mul_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  f3_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] wbd_q;

  logic        req;
  logic        go;
  logic        hit;
  logic [31:0] c_data;
  logic        c_wr;
  logic        tmo;

  assign req = ex_valid & ex_is_mul & ~flush;

  // mul_ready still high means the Multiplier has not drained yet
  assign go = req &
              (f3_to_mulsel(ex_funct3) != MS_IDLE) &
              ~mif.mul_ready;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  assign c_wr = (state_q == BUSY) &
                ~flush & mif.mul_ready;

  mul_result_cache #(
    .EN(CACHE_EN)
  ) u_cache (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (c_wr),
    .inv     (1'b0),
    .wr_f3   (f3_q),
    .wr_a    (a_q),
    .wr_b    (b_q),
    .wr_data (mif.mul_res),
    .lk_f3   (ex_funct3),
    .lk_a    (ex_rs1),
    .lk_b    (ex_rs2),
    .hit     (hit),
    .rd_data (c_data)
  );

  always_comb begin
    state_d     = state_q;
    mif.mul_sel = MS_IDLE;
    mul_err     = 1'b0;
    wb_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go)
          state_d = hit ? DONE : BUSY;
      end
      BUSY: begin
        // mul_sel=000 is also what aborts the Multiplier
        mif.mul_sel = f3_to_mulsel(f3_q);
        if (flush) begin
          state_d = IDLE;
        end else if (mif.mul_ready) begin
          state_d = DONE;
        end else if (tmo) begin
          mul_err = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid = ~flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall     = req & (state_q != DONE);
  assign mif.mul_a = a_q;
  assign mif.mul_b = b_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wbd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wbd_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && go) begin
        f3_q  <= ex_funct3;
        a_q   <= ex_rs1;
        b_q   <= ex_rs2;
        rd_q  <= ex_rd;
        cnt_q <= '0;
        if (hit)
          wbd_q <= c_data;
      end
      if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        if (!flush && mif.mul_ready)
          wbd_q <= mif.mul_res;
        else if (mul_err)
          wbd_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a 1-cycle Multiplier stub.
// Two instances: cached (u_a) and CACHE_EN=0 (u_b).
module tb_mul_issue_ctrl;
  import mext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_valid_b;
  logic        ex_is_mul;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        hang = 1'b0;

  logic        stall, wb_valid, mul_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_b, wb_valid_b, mul_err_b;
  logic [4:0]  wb_rd_b;
  logic [31:0] wb_data_b;

  logic        rdy_a = 1'b0;
  logic        rdy_b = 1'b0;
  logic [31:0] res_a = '0;
  logic [31:0] res_b = '0;

  int checks = 0;
  int errors = 0;

  mul_issue_ctrl_if mif_a ();
  mul_issue_ctrl_if mif_b ();

  assign mif_a.mul_ready = rdy_a;
  assign mif_a.mul_res   = res_a;
  assign mif_b.mul_ready = rdy_b;
  assign mif_b.mul_res   = res_b;

  mul_issue_ctrl #(
    .CACHE_EN(1'b1),
    .TIMEOUT (15)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_is_mul (ex_is_mul),
    .ex_funct3 (ex_funct3),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rd     (ex_rd),
    .flush     (flush),
    .mif       (mif_a),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mul_err   (mul_err)
  );

  mul_issue_ctrl #(
    .CACHE_EN(1'b0),
    .TIMEOUT (15)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid_b),
    .ex_is_mul (ex_is_mul),
    .ex_funct3 (ex_funct3),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rd     (ex_rd),
    .flush     (flush),
    .mif       (mif_b),
    .stall     (stall_b),
    .wb_valid  (wb_valid_b),
    .wb_rd     (wb_rd_b),
    .wb_data   (wb_data_b),
    .mul_err   (mul_err_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl(
    input logic [2:0]  s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (s == MS_MULH || s == MS_MULHSU)
      ea = {{32{a[31]}}, a};
    if (s == MS_MULH)
      eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (s == MS_MUL) ? p[31:0] : p[63:32];
  endfunction

  // ready one cycle after a nonzero select, drops once select is 000
  always @(posedge clk) begin
    if (mif_a.mul_sel != MS_IDLE && !hang) begin
      rdy_a <= 1'b1;
      res_a <= mdl(mif_a.mul_sel, mif_a.mul_a, mif_a.mul_b);
    end else begin
      rdy_a <= 1'b0;
    end
    if (mif_b.mul_sel != MS_IDLE && !hang) begin
      rdy_b <= 1'b1;
      res_b <= mdl(mif_b.mul_sel, mif_b.mul_a, mif_b.mul_b);
    end else begin
      rdy_b <= 1'b0;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd
  );
    ex_valid  = 1'b1;
    ex_is_mul = 1'b1;
    ex_funct3 = f3;
    ex_rs1    = a;
    ex_rs2    = b;
    ex_rd     = rd;
  endtask

  task automatic idle_ex();
    ex_valid   = 1'b0;
    ex_valid_b = 1'b0;
    ex_is_mul  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_sel"}, 32'(mif_a.mul_sel), 0);
    check({tag, "_a"}, mif_a.mul_a, 0);
    check({tag, "_b"}, mif_a.mul_b, 0);
    check({tag, "_wbv"}, 32'(wb_valid), 0);
    check({tag, "_wbrd"}, 32'(wb_rd), 0);
    check({tag, "_wbd"}, wb_data, 0);
    check({tag, "_err"}, 32'(mul_err), 0);
  endtask

  initial begin
    rst        = 1'b0;
    flush      = 1'b0;
    ex_valid   = 1'b0;
    ex_valid_b = 1'b0;
    ex_is_mul  = 1'b0;
    ex_funct3  = '0;
    ex_rs1     = '0;
    ex_rs2     = '0;
    ex_rd      = '0;
    #12;
    check_reset("rst0");
    mid();
    rst = 1'b1;
    tick();

    // MUL 7x6, uncached
    drive(F3_MUL, 32'd7, 32'd6, 5'd5);
    mid();
    check("mul_c0_stall", 32'(stall), 1);
    check("mul_c0_sel", 32'(mif_a.mul_sel), 0);
    tick(); mid();
    check("mul_c1_stall", 32'(stall), 1);
    check("mul_c1_sel", 32'(mif_a.mul_sel), 1);
    check("mul_c1_a", mif_a.mul_a, 7);
    check("mul_c1_b", mif_a.mul_b, 6);
    tick(); mid();
    check("mul_c2_stall", 32'(stall), 1);
    check("mul_c2_wbv", 32'(wb_valid), 0);
    tick(); mid();
    check("mul_c3_wbv", 32'(wb_valid), 1);
    check("mul_c3_wbd", wb_data, 42);
    check("mul_c3_rd", 32'(wb_rd), 5);
    check("mul_c3_stall", 32'(stall), 0);
    check("mul_c3_sel", 32'(mif_a.mul_sel), 0);
    tick();

    // repeat MUL 7x6 -> cache hit
    drive(F3_MUL, 32'd7, 32'd6, 5'd7);
    mid();
    check("hit_c0_stall", 32'(stall), 1);
    check("hit_c0_sel", 32'(mif_a.mul_sel), 0);
    tick(); mid();
    check("hit_c1_wbv", 32'(wb_valid), 1);
    check("hit_c1_wbd", wb_data, 42);
    check("hit_c1_rd", 32'(wb_rd), 7);
    check("hit_c1_sel", 32'(mif_a.mul_sel), 0);
    tick();

    // MULH then back-to-back MULHU
    drive(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd8);
    mid();
    check("mulh_c0_stall", 32'(stall), 1);
    tick(); mid();
    check("mulh_c1_sel", 32'(mif_a.mul_sel), 2);
    tick(); tick(); mid();
    check("mulh_c3_wbv", 32'(wb_valid), 1);
    check("mulh_c3_wbd", wb_data, 32'h4000_0000);
    tick();
    drive(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    mid();
    check("mulhu_c0_rdy", 32'(rdy_a), 0);
    check("mulhu_c0_stall", 32'(stall), 1);
    tick(); mid();
    check("mulhu_c1_sel", 32'(mif_a.mul_sel), 4);
    tick(); tick(); mid();
    check("mulhu_c3_wbv", 32'(wb_valid), 1);
    check("mulhu_c3_wbd", wb_data, 32'hFFFF_FFFE);
    tick();

    // MULHSU flushed in its second BUSY cycle
    drive(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd10);
    mid();
    tick(); mid();
    check("fl_c1_sel", 32'(mif_a.mul_sel), 3);
    tick();
    flush = 1'b1;
    mid();
    check("fl_c2_rdy", 32'(rdy_a), 1);
    check("fl_c2_stall", 32'(stall), 0);
    check("fl_c2_wbv", 32'(wb_valid), 0);
    tick();
    flush = 1'b0;
    drive(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    mid();
    check("fl_c3_sel", 32'(mif_a.mul_sel), 0);
    check("fl_c3_wbv", 32'(wb_valid), 0);
    check("fl_c3_rdy", 32'(rdy_a), 1);
    check("fl_c3_stall", 32'(stall), 1);
    tick(); mid();
    check("fl_c4_rdy", 32'(rdy_a), 0);
    check("fl_c4_stall", 32'(stall), 1);
    check("fl_c4_sel", 32'(mif_a.mul_sel), 0);
    tick(); mid();
    check("fl_c5_wbv", 32'(wb_valid), 1);
    check("fl_c5_wbd", wb_data, 32'hFFFF_FFFE);
    check("fl_c5_rd", 32'(wb_rd), 11);
    tick();
    idle_ex();

    // CACHE_EN=0: repeated MUL 7x6 always takes the full path
    for (int r = 0; r < 2; r++) begin
      drive(F3_MUL, 32'd7, 32'd6, 5'd12);
      ex_valid   = 1'b0;
      ex_valid_b = 1'b1;
      mid();
      check("nc_c0_stall", 32'(stall_b), 1);
      tick(); mid();
      check("nc_c1_wbv", 32'(wb_valid_b), 0);
      check("nc_c1_sel", 32'(mif_b.mul_sel), 1);
      tick(); tick(); mid();
      check("nc_c3_wbv", 32'(wb_valid_b), 1);
      check("nc_c3_wbd", wb_data_b, 42);
      tick();
    end
    idle_ex();

    // Multiplier never ready -> timeout
    hang = 1'b1;
    drive(F3_MUL, 32'd9, 32'd9, 5'd13);
    mid();
    check("to_c0_stall", 32'(stall), 1);
    for (int i = 1; i < 15; i++) begin
      tick(); mid();
      check("to_busy", {28'b0, mul_err, mif_a.mul_sel}, 32'h1);
    end
    tick(); mid();
    check("to_c15_err", 32'(mul_err), 1);
    check("to_c15_sel", 32'(mif_a.mul_sel), 1);
    tick(); mid();
    check("to_c16_wbv", 32'(wb_valid), 1);
    check("to_c16_wbd", wb_data, 0);
    check("to_c16_rd", 32'(wb_rd), 13);
    check("to_c16_err", 32'(mul_err), 0);
    hang = 1'b0;
    tick();
    idle_ex();

    // reset during BUSY, then MUL 3x5 must not hit
    tick();
    drive(F3_MUL, 32'd3, 32'd5, 5'd14);
    tick(); tick(); tick(); mid();
    check("pre_wbd", wb_data, 15);
    tick();
    drive(F3_MUL, 32'd4, 32'd4, 5'd15);
    tick(); mid();
    check("rb_c1_sel", 32'(mif_a.mul_sel), 1);
    #1;
    rst = 1'b0;
    idle_ex();
    #1;
    check_reset("rst1");
    mid(); mid();
    rst = 1'b1;
    tick();
    drive(F3_MUL, 32'd3, 32'd5, 5'd16);
    mid();
    check("ar_c0_stall", 32'(stall), 1);
    tick(); mid();
    check("ar_c1_wbv", 32'(wb_valid), 0);
    check("ar_c1_sel", 32'(mif_a.mul_sel), 1);
    tick(); tick(); mid();
    check("ar_c3_wbv", 32'(wb_valid), 1);
    check("ar_c3_wbd", wb_data, 15);
    check("ar_c3_rd", 32'(wb_rd), 16);
    tick();
    idle_ex();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
